// File: rtl/RV32A.sv
// RV32A: shared definitions for the atomic-memory-operation (A extension)
// datapath.
//   opcode_e    : major opcode of the AMO instruction group
//   func3_e     : width field; only word-sized atomics are supported
//   func5_e     : atomic operation selector (LR, SC and the AMO* family)
//   amo_state_e : sequencing states of amo_ctrl
//   RESV_LSB    : reservation granularity; reservations cover one 32-bit word
package RV32A;

    typedef enum logic [6:0] {
        OPC_AMO = 7'b0101111
    } opcode_e;

    typedef enum logic [2:0] {
        FUNC3_A_W = 3'b010
    } func3_e;

    typedef enum logic [4:0] {
        F5_ADD  = 5'b00000,
        F5_SWAP = 5'b00001,
        F5_LR   = 5'b00010,
        F5_SC   = 5'b00011,
        F5_XOR  = 5'b00100,
        F5_OR   = 5'b01000,
        F5_AND  = 5'b01100,
        F5_MIN  = 5'b10000,
        F5_MAX  = 5'b10100,
        F5_MINU = 5'b11000,
        F5_MAXU = 5'b11100
    } func5_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } amo_state_e;

    // Address bits below this index are ignored when matching reservations.
    localparam int unsigned RESV_LSB = 2;

    function automatic logic func5_defined(input logic [4:0] f);
        case (f)
            F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/amo_alu.sv
// amo_alu: combinational read-modify-write function for AMO* operations.
//   func5_i  : atomic operation selector (func5_e encoding)
//   old_i    : value read from memory
//   rs2_i    : register operand
//   result_o : value to write back to memory
module amo_alu
    import RV32A::*;
(
    input  logic [4:0]  func5_i,
    input  logic [31:0] old_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(old_i) < $signed(rs2_i);
    assign lt_unsigned = old_i < rs2_i;

    always_comb begin
        result_o = rs2_i;
        case (func5_i)
            F5_SWAP: result_o = rs2_i;
            F5_ADD:  result_o = old_i + rs2_i;
            F5_XOR:  result_o = old_i ^ rs2_i;
            F5_AND:  result_o = old_i & rs2_i;
            F5_OR:   result_o = old_i | rs2_i;
            F5_MIN:  result_o = lt_signed   ? old_i : rs2_i;
            F5_MAX:  result_o = lt_signed   ? rs2_i : old_i;
            F5_MINU: result_o = lt_unsigned ? old_i : rs2_i;
            F5_MAXU: result_o = lt_unsigned ? rs2_i : old_i;
            default: result_o = rs2_i;
        endcase
    end

endmodule

// File: rtl/amo_ctrl.sv
// amo_ctrl: sequencer for RV32A atomics (LR.W, SC.W, AMO*.W), one in flight.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request from issue (func3/func5/addr/rs2/tag)
//   mem_req_valid/mem_req_ready   : word memory request (we, addr, wdata)
//   mem_rsp_valid/mem_rdata       : read data, only honoured in RD_WAIT
//   rsp_valid/rsp_ready           : result to writeback (data, err, tag)
//   snoop_valid/snoop_addr, flush : reservation kill sources
module amo_ctrl
    import RV32A::*;
#(
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_func3,
    input  logic [4:0]       req_func5,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_rsp_valid,
    input  logic [31:0]      mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    input  logic             snoop_valid,
    input  logic [31:0]      snoop_addr,
    input  logic             flush
);

    amo_state_e state_q, state_d;

    logic [4:0]           func5_q;
    logic [31:0]          addr_q;
    logic [31:0]          data_q;
    logic [TAG_W-1:0]     tag_q;
    logic [31:0]          rsp_data_q;
    logic                 rsp_err_q;
    logic                 resv_valid_q, resv_valid_d;
    logic [31:RESV_LSB]   resv_addr_q, resv_addr_d;
    logic                 lr_kill_q;

    logic        accept;
    logic        req_bad;
    logic        req_is_sc;
    logic        sc_ok;
    logic        rd_done;
    logic        kill_resv;
    logic        lr_kill_acc;
    logic        lr_kill_fly;
    logic [31:0] alu_result;
    logic        unused_snoop_lsb;

    assign unused_snoop_lsb = ^snoop_addr[RESV_LSB-1:0];

    assign accept    = req_valid && (state_q == IDLE);
    assign req_bad   = (req_addr[1:0] != 2'b00) || (req_func3 != FUNC3_A_W)
                       || !func5_defined(req_func5);
    assign req_is_sc = (req_func5 == F5_SC);
    assign rd_done   = (state_q == RD_WAIT) && mem_rsp_valid;

    // A kill arriving in the SC accept cycle wins over the reservation.
    assign kill_resv = flush || (snoop_valid && (snoop_addr[31:RESV_LSB] == resv_addr_q));
    assign sc_ok     = resv_valid_q && !kill_resv
                       && (resv_addr_q == req_addr[31:RESV_LSB]);

    // Kills seen while an LR is in flight are remembered so the reservation
    // it installs on RD_WAIT exit is born already invalid.
    assign lr_kill_acc = flush || (snoop_valid && (snoop_addr[31:RESV_LSB] == req_addr[31:RESV_LSB]));
    assign lr_kill_fly = flush || (snoop_valid && (snoop_addr[31:RESV_LSB] == addr_q[31:RESV_LSB]));

    // rsp_data_q doubles as the old-value register: it is loaded with the
    // read data on RD_WAIT exit and stays untouched through WR_REQ.
    amo_alu u_alu (
        .func5_i  (func5_q),
        .old_i    (rsp_data_q),
        .rs2_i    (data_q),
        .result_o (alu_result)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)        state_d = RESP;
                    else if (req_is_sc) state_d = sc_ok ? WR_REQ : RESP;
                    else                state_d = RD_REQ;
                end
            end
            RD_REQ:  if (mem_req_ready) state_d = RD_WAIT;
            RD_WAIT: if (mem_rsp_valid) state_d = (func5_q == F5_LR) ? RESP : WR_REQ;
            WR_REQ:  if (mem_req_ready) state_d = RESP;
            RESP:    if (rsp_ready)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready     = (state_q == IDLE);
        mem_req_valid = (state_q == RD_REQ) || (state_q == WR_REQ);
        mem_we        = (state_q == WR_REQ);
        mem_addr      = addr_q;
        mem_wdata     = '0;
        if (state_q == WR_REQ) begin
            mem_wdata = (func5_q == F5_SC) ? data_q : alu_result;
        end
        rsp_valid     = (state_q == RESP);
        rsp_data      = rsp_data_q;
        rsp_err       = rsp_err_q;
        rsp_tag       = tag_q;
    end

    // Reservation next state
    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        if (kill_resv) begin
            resv_valid_d = 1'b0;
        end
        if (accept && req_is_sc) begin
            resv_valid_d = 1'b0;
        end
        if (rd_done && (func5_q == F5_LR)) begin
            resv_valid_d = !(lr_kill_q || lr_kill_fly);
            resv_addr_d  = addr_q[31:RESV_LSB];
        end
    end

    // Request capture, result and reservation registers
    always_ff @(posedge clk) begin
        if (rst) begin
            func5_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            tag_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
            lr_kill_q    <= 1'b0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
            if (accept) begin
                func5_q    <= req_func5;
                addr_q     <= req_addr;
                data_q     <= req_data;
                tag_q      <= req_tag;
                rsp_err_q  <= req_bad;
                rsp_data_q <= (!req_bad && req_is_sc && !sc_ok) ? 32'd1 : 32'd0;
                lr_kill_q  <= lr_kill_acc;
            end else begin
                lr_kill_q <= lr_kill_q || lr_kill_fly;
                if (rd_done) begin
                    rsp_data_q <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_amo_ctrl.sv
// tb_amo_ctrl: directed-vector bench for amo_ctrl with a behavioural word
// memory (read data returned one cycle after the read handshake).
module tb_amo_ctrl;

    localparam int unsigned TAG_W = 6;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;
    localparam logic [2:0] F3_W    = 3'b010;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_func3;
    logic [4:0]       req_func5;
    logic [31:0]      req_addr;
    logic [31:0]      req_data;
    logic [TAG_W-1:0] req_tag;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_rsp_valid;
    logic [31:0]      mem_rdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             snoop_valid;
    logic [31:0]      snoop_addr;
    logic             flush;

    int n_vec;
    int n_miss;

    logic [31:0] mem [logic [31:0]];
    logic        auto_rsp;
    logic        inj_rsp;
    logic        hold_rsp;
    int          wr_cnt;
    int          mreq_cnt;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    logic [TAG_W-1:0] tag_ctr;

    assign mem_rsp_valid = auto_rsp | inj_rsp;

    amo_ctrl #(.TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_func3     (req_func3),
        .req_func5     (req_func5),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .rsp_tag       (rsp_tag),
        .snoop_valid   (snoop_valid),
        .snoop_addr    (snoop_addr),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: writes land on the handshake edge, read data follows
    // one cycle after the read handshake.
    always @(posedge clk) begin
        logic        rd_hs;
        logic [31:0] ra;
        rd_hs = !rst && mem_req_valid && mem_req_ready && !mem_we && !hold_rsp;
        ra    = mem_addr;
        if (!rst && mem_req_valid && mem_req_ready && mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
        #1;
        auto_rsp  = rd_hs;
        mem_rdata = (rd_hs && mem.exists(ra)) ? mem[ra] : 32'h0;
    end

    always @(negedge clk) if (mem_req_valid) mreq_cnt++;

    // Stalled memory requests must hold address, direction and data.
    logic        pend;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    always @(posedge clk) begin
        pend    = !rst && mem_req_valid && !mem_req_ready;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
    end
    always @(negedge clk) begin
        if (pend && !rst) begin
            check("mreq_hold_valid", {31'd0, mem_req_valid}, 32'd1);
            check("mreq_hold_we",    {31'd0, mem_we}, {31'd0, p_we});
            check("mreq_hold_addr",  mem_addr, p_addr);
            check("mreq_hold_wdata", mem_wdata, p_wdata);
        end
    end

    // One complete transaction with rsp_ready high. Latency counts the accept
    // cycle as cycle 1 and reports the first cycle with rsp_valid high.
    task automatic op(input string nm, input logic [4:0] f5, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] data, input bit snp,
                      input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                      input bit exp_wr, input logic [31:0] exp_wdata, input bit exp_noacc);
        int lat;
        int wr0;
        int mq0;
        logic [TAG_W-1:0] tg;
        wr0 = wr_cnt;
        mq0 = mreq_cnt;
        tg  = tag_ctr;
        tag_ctr = tag_ctr + 1'b1;
        check({nm, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_func5 = f5;
        req_func3 = f3;
        req_addr  = addr;
        req_data  = data;
        req_tag   = tg;
        if (snp) begin
            snoop_valid = 1'b1;
            snoop_addr  = addr;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (snp) snoop_valid = 1'b0;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        check({nm, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({nm, ".latency"},   32'(lat), 32'(exp_lat));
        check({nm, ".rsp_data"},  rsp_data, exp_data);
        check({nm, ".rsp_err"},   {31'd0, rsp_err}, {31'd0, exp_err});
        check({nm, ".rsp_tag"},   32'(rsp_tag), 32'(tg));
        @(posedge clk);
        @(negedge clk);
        check({nm, ".back_idle"}, {31'd0, req_ready}, 32'd1);
        check({nm, ".wr_count"},  32'(wr_cnt - wr0), exp_wr ? 32'd1 : 32'd0);
        if (exp_wr) begin
            check({nm, ".waddr"}, last_waddr, addr);
            check({nm, ".wdata"}, last_wdata, exp_wdata);
        end
        if (exp_noacc) check({nm, ".no_mem_req"}, 32'(mreq_cnt - mq0), 32'd0);
    endtask

    task automatic pulse_snoop(input logic [31:0] a);
        snoop_valid = 1'b1;
        snoop_addr  = a;
        @(negedge clk);
        snoop_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_miss = 0; wr_cnt = 0; mreq_cnt = 0; tag_ctr = 6'd9;
        auto_rsp = 1'b0; inj_rsp = 1'b0; hold_rsp = 1'b0; mem_rdata = '0;
        last_waddr = '0; last_wdata = '0;
        rst = 1'b1; req_valid = 1'b0; req_func3 = '0; req_func5 = '0;
        req_addr = '0; req_data = '0; req_tag = '0;
        mem_req_ready = 1'b1; rsp_ready = 1'b1;
        snoop_valid = 1'b0; snoop_addr = '0; flush = 1'b0;
        mem[32'h100] = 32'd5;        mem[32'h110] = 32'd10;
        mem[32'h200] = 32'h1234;     mem[32'h300] = 32'hFFFF_FFFF;
        mem[32'h304] = 32'h8000_0000; mem[32'h308] = 32'h0000_F0F0;
        mem[32'h700] = 32'h77;       mem[32'h800] = 32'h5A5A;
        mem[32'h900] = 32'h9;        mem[32'hE00] = 32'h1;

        repeat (3) @(negedge clk);
        check("rst.req_ready",     {31'd0, req_ready}, 32'd1);
        check("rst.mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst.mem_we",        {31'd0, mem_we}, 32'd0);
        check("rst.rsp_valid",     {31'd0, rsp_valid}, 32'd0);
        check("rst.rsp_err",       {31'd0, rsp_err}, 32'd0);
        check("rst.rsp_data",      rsp_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //  name         func5    f3    addr          rs2           snp  rsp_data       err lat wr wdata         noacc
        op("amoadd",    F5_ADD,  F3_W, 32'h100, 32'd3,          0, 32'd5,          0, 5, 1, 32'd8,          0);
        op("lr",        F5_LR,   F3_W, 32'h200, 32'd0,          0, 32'h1234,       0, 4, 0, 32'd0,          0);
        op("sc_ok",     F5_SC,   F3_W, 32'h200, 32'hAA,         0, 32'd0,          0, 3, 1, 32'hAA,         0);
        op("sc_again",  F5_SC,   F3_W, 32'h200, 32'hBB,         0, 32'd1,          0, 2, 0, 32'd0,          1);
        op("lr2",       F5_LR,   F3_W, 32'h200, 32'd0,          0, 32'hAA,         0, 4, 0, 32'd0,          0);
        pulse_snoop(32'h203);
        op("sc_snooped",F5_SC,   F3_W, 32'h200, 32'hCC,         0, 32'd1,          0, 2, 0, 32'd0,          1);
        op("amomin",    F5_MIN,  F3_W, 32'h300, 32'd1,          0, 32'hFFFF_FFFF,  0, 5, 1, 32'hFFFF_FFFF,  0);
        op("amominu",   F5_MINU, F3_W, 32'h300, 32'd1,          0, 32'hFFFF_FFFF,  0, 5, 1, 32'd1,          0);
        op("amomax",    F5_MAX,  F3_W, 32'h304, 32'd5,          0, 32'h8000_0000,  0, 5, 1, 32'd5,          0);
        op("amomaxu",   F5_MAXU, F3_W, 32'h304, 32'h8000_0000,  0, 32'd5,          0, 5, 1, 32'h8000_0000,  0);
        op("amoadd_wr", F5_ADD,  F3_W, 32'h304, 32'h8000_0000,  0, 32'h8000_0000,  0, 5, 1, 32'd0,          0);
        op("amoxor",    F5_XOR,  F3_W, 32'h308, 32'h0FF0,       0, 32'hF0F0,       0, 5, 1, 32'hFF00,       0);
        op("amoand",    F5_AND,  F3_W, 32'h308, 32'h0FF0,       0, 32'hFF00,       0, 5, 1, 32'h0F00,       0);
        op("amoor",     F5_OR,   F3_W, 32'h308, 32'h000F,       0, 32'h0F00,       0, 5, 1, 32'h0F0F,       0);
        op("amoswap",   F5_SWAP, F3_W, 32'h308, 32'hDEAD,       0, 32'h0F0F,       0, 5, 1, 32'hDEAD,       0);
        op("err_align", F5_SWAP, F3_W, 32'h102, 32'h1,          0, 32'd0,          1, 2, 0, 32'd0,          1);
        op("err_func3", F5_ADD,  3'b011, 32'h100, 32'h1,        0, 32'd0,          1, 2, 0, 32'd0,          1);
        op("err_func5", 5'b00101, F3_W, 32'h100, 32'h1,         0, 32'd0,          1, 2, 0, 32'd0,          1);
        op("err_lr",    F5_LR,   F3_W, 32'h201, 32'h0,          0, 32'd0,          1, 2, 0, 32'd0,          1);

        // Flush between LR and SC
        op("lr_a00",    F5_LR,   F3_W, 32'hA00, 32'd0,          0, 32'd0,          0, 4, 0, 32'd0,          0);
        flush = 1'b1; @(negedge clk); flush = 1'b0; @(negedge clk);
        op("sc_flushed",F5_SC,   F3_W, 32'hA00, 32'h1,          0, 32'd1,          0, 2, 0, 32'd0,          1);
        // Snoop in the same cycle as SC accept
        op("lr_b00",    F5_LR,   F3_W, 32'hB00, 32'd0,          0, 32'd0,          0, 4, 0, 32'd0,          0);
        op("sc_samecyc",F5_SC,   F3_W, 32'hB00, 32'h2,          1, 32'd1,          0, 2, 0, 32'd0,          1);
        // Address mismatch fails and still clears the reservation
        op("lr_c00",    F5_LR,   F3_W, 32'hC00, 32'd0,          0, 32'd0,          0, 4, 0, 32'd0,          0);
        op("sc_c04",    F5_SC,   F3_W, 32'hC04, 32'h3,          0, 32'd1,          0, 2, 0, 32'd0,          1);
        op("sc_c00",    F5_SC,   F3_W, 32'hC00, 32'h3,          0, 32'd1,          0, 2, 0, 32'd0,          1);
        // Snoop to a neighbouring word does not kill the reservation
        op("lr_d00",    F5_LR,   F3_W, 32'hD00, 32'd0,          0, 32'd0,          0, 4, 0, 32'd0,          0);
        pulse_snoop(32'hD04);
        op("sc_d00",    F5_SC,   F3_W, 32'hD00, 32'h44,         0, 32'd0,          0, 3, 1, 32'h44,         0);

        // Matching snoop while the LR is in flight
        fork
            op("lr_900", F5_LR,  F3_W, 32'h900, 32'd0,          0, 32'h9,          0, 4, 0, 32'd0,          0);
            begin
                @(negedge clk);
                snoop_valid = 1'b1; snoop_addr = 32'h901;
                @(negedge clk);
                snoop_valid = 1'b0;
            end
        join
        op("sc_900",    F5_SC,   F3_W, 32'h900, 32'h5,          0, 32'd1,          0, 2, 0, 32'd0,          1);

        // Flush does not abort an in-flight AMO
        fork
            op("add_flush", F5_ADD, F3_W, 32'hE00, 32'd1,       0, 32'd1,          0, 5, 1, 32'd2,          0);
            begin
                @(negedge clk); @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join

        // Memory backpressure on both the read and the write request
        mem_req_ready = 1'b0;
        fork
            op("add_bp",    F5_ADD, F3_W, 32'h110, 32'd7,       0, 32'd10,         0, 8, 1, 32'd17,         0);
            begin
                repeat (3) @(negedge clk);
                mem_req_ready = 1'b1;
                repeat (2) @(negedge clk);
                mem_req_ready = 1'b0;
                @(negedge clk);
                mem_req_ready = 1'b1;
            end
        join

        // Writeback backpressure: response held stable
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_func5 = F5_LR; req_func3 = F3_W;
        req_addr = 32'h800; req_data = '0; req_tag = 6'd33;
        @(posedge clk); #1; req_valid = 1'b0;
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold.rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold.rsp_data",  rsp_data, 32'h5A5A);
            check("hold.rsp_tag",   32'(rsp_tag), 32'd33);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("hold.released", {31'd0, rsp_valid}, 32'd0);

        // Reset while waiting for read data
        op("lr_700",    F5_LR,   F3_W, 32'h700, 32'd0,          0, 32'h77,         0, 4, 0, 32'd0,          0);
        hold_rsp = 1'b1;
        req_valid = 1'b1; req_func5 = F5_LR; req_func3 = F3_W;
        req_addr = 32'h700; req_tag = 6'd1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        check("rdwait.rd_req", {31'd0, mem_req_valid}, 32'd1);
        @(negedge clk);
        check("rdwait.in_wait", {31'd0, mem_req_valid | rsp_valid | req_ready}, 32'd0);
        rst = 1'b1; mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rdwait.rst_ready", {31'd0, req_ready}, 32'd1);
        check("rdwait.rst_mreq",  {31'd0, mem_req_valid}, 32'd0);
        check("rdwait.rst_rsp",   {31'd0, rsp_valid}, 32'd0);
        inj_rsp = 1'b1; mem_rdata = 32'hBEEF;
        @(negedge clk);
        inj_rsp = 1'b0;
        hold_rsp = 1'b0;
        @(negedge clk);
        check("late_rsp.ready", {31'd0, req_ready}, 32'd1);
        check("late_rsp.rsp",   {31'd0, rsp_valid}, 32'd0);
        check("late_rsp.mreq",  {31'd0, mem_req_valid}, 32'd0);
        mem_req_ready = 1'b1;
        op("sc_after_rst", F5_SC, F3_W, 32'h700, 32'h6,         0, 32'd1,          0, 2, 0, 32'd0,          1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
